// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
//   Hazard and stall controller for a five-stage pipeline. It decides, every
//   cycle, which pipeline latches capture (en) and which load a bubble
//   (flush). The decision depends on the current FSM state and on the
//   hazards visible this cycle. A halt instruction drains the pipeline, and
//   the unit then parks in HALTED until reset.
//
//   Optional feature: define PIPE_PERF_CNT_EN to build the two 16-bit
//   saturating performance counters. Without it, both counter outputs are
//   tied to zero and no counter flops exist.
//
// Ports
//   CLK, RST                  clock; asynchronous active-high reset
//   ihit, dhit                instruction fetch / data access complete
//   dmemREN_MEM, dmemWEN_MEM  MEM-stage load / store pending
//   memtoReg_EX, Wsel_EX      EX-stage load and its destination register
//   rs_ID, rt_ID, usesRt_ID   ID-stage source registers
//   redirect_MEM, halt_MEM    taken branch/jump, halt instruction in MEM
//   pc_en .. memwb_flush      enables/flushes for PC and the four latches
//   halted                    processor stopped
//   stall_cycles, flush_events performance counters
module pipeline_control_unit (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       dmemREN_MEM,
    input  logic       dmemWEN_MEM,
    input  logic       memtoReg_EX,
    input  logic [4:0] Wsel_EX,
    input  logic [4:0] rs_ID,
    input  logic [4:0] rt_ID,
    input  logic       usesRt_ID,
    input  logic       redirect_MEM,
    input  logic       halt_MEM,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_flush,
    output logic       exmem_en,
    output logic       exmem_flush,
    output logic       memwb_en,
    output logic       memwb_flush,
    output logic       halted,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

    state_t state_q, state_d;
    logic   memwait;
    logic   loaduse;
    logic   active;

    assign memwait = (dmemREN_MEM | dmemWEN_MEM) & ~dhit;
    assign loaduse = memtoReg_EX & (Wsel_EX != 5'd0) &
                     ((Wsel_EX == rs_ID) | (usesRt_ID & (Wsel_EX == rt_ID)));
    // MEMWAIT resolves exactly like RUN: once dhit arrives memwait drops,
    // and the remaining hazards are evaluated in that same cycle.
    assign active  = (state_q == RUN) || (state_q == MEMWAIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        case (state_q)
            RUN, MEMWAIT: begin
                if (memwait) begin
                    // Freeze everything upstream of MEM; WB gets a bubble.
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_en    = 1'b0;
                    memwb_flush = 1'b1;
                    state_d     = MEMWAIT;
                end else begin
                    state_d = RUN;
                    if (halt_MEM) begin
                        // Let the halt retire into WB, squash the younger ones.
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        ifid_flush  = 1'b1;
                        idex_en     = 1'b0;
                        idex_flush  = 1'b1;
                        exmem_en    = 1'b0;
                        exmem_flush = 1'b1;
                        state_d     = DRAIN;
                    end else if (redirect_MEM) begin
                        // PC loads the target even on a fetch miss.
                        ifid_en     = 1'b0;
                        ifid_flush  = 1'b1;
                        idex_en     = 1'b0;
                        idex_flush  = 1'b1;
                        exmem_en    = 1'b0;
                        exmem_flush = 1'b1;
                    end else if (loaduse) begin
                        // Hold PC and IF/ID, insert a bubble into EX.
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
            end
            DRAIN: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_en    = 1'b0;
                memwb_flush = 1'b1;
                state_d     = HALTED;
            end
            HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                halted   = 1'b1;
            end
            default: state_d = RUN;
        endcase
        // Reset overrides the outputs combinationally so they respond
        // immediately, not at the next clock edge.
        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
            halted      = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        stall_evt;
    logic        redirect_evt;

    // Both events are zero in DRAIN/HALTED, so the counters freeze there.
    assign stall_evt    = active & ~pc_en;
    assign redirect_evt = active & ~memwait & ~halt_MEM & redirect_MEM;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (redirect_evt && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    assign stall_cycles = 16'd0;
    assign flush_events = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX;
    logic [4:0] Wsel_EX, rs_ID, rt_ID;
    logic       usesRt_ID, redirect_MEM, halt_MEM;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic       exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
    logic [15:0] stall_cycles, flush_events;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    pipeline_control_unit dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_MEM(dmemREN_MEM), .dmemWEN_MEM(dmemWEN_MEM),
        .memtoReg_EX(memtoReg_EX), .Wsel_EX(Wsel_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .usesRt_ID(usesRt_ID),
        .redirect_MEM(redirect_MEM), .halt_MEM(halt_MEM),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halted(halted), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
    logic [8:0] outs;
    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_flush, memwb_en, memwb_flush};

    localparam logic [8:0] V_NORMAL  = 9'b1_10_10_10_10;
    localparam logic [8:0] V_MEMWAIT = 9'b0_00_00_00_01;
    localparam logic [8:0] V_HALT    = 9'b0_01_01_01_10;
    localparam logic [8:0] V_REDIR   = 9'b1_01_01_01_10;
    localparam logic [8:0] V_LOADUSE = 9'b0_00_01_10_10;
    localparam logic [8:0] V_IMISS   = 9'b0_01_10_10_10;
    localparam logic [8:0] V_DRAIN   = 9'b0_00_00_00_01;
    localparam logic [8:0] V_HALTED  = 9'b0_00_00_00_00;
    localparam logic [8:0] V_RESET   = 9'b0_01_01_01_01;

    typedef struct {
        string      name;
        logic       ihit, dhit, ren, wen, m2r;
        logic [4:0] wsel, rs, rt;
        logic       usesrt, redir, halt;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_idle();
        ihit = 1'b1; dhit = 1'b0; dmemREN_MEM = 1'b0; dmemWEN_MEM = 1'b0;
        memtoReg_EX = 1'b0; Wsel_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
        usesRt_ID = 1'b0; redirect_MEM = 1'b0; halt_MEM = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        set_idle();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"normal",          1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0, V_NORMAL};
        vecs[1]  = '{"loaduse_rs",      1,0,0,0,1, 5'd5, 5'd5, 5'd0, 0,0,0, V_LOADUSE};
        vecs[2]  = '{"loaduse_r0",      1,0,0,0,1, 5'd0, 5'd0, 5'd0, 1,0,0, V_NORMAL};
        vecs[3]  = '{"loaduse_rt",      1,0,0,0,1, 5'd9, 5'd3, 5'd9, 1,0,0, V_LOADUSE};
        vecs[4]  = '{"rt_not_used",     1,0,0,0,1, 5'd9, 5'd3, 5'd9, 0,0,0, V_NORMAL};
        vecs[5]  = '{"no_load_match",   1,0,0,0,0, 5'd7, 5'd7, 5'd7, 1,0,0, V_NORMAL};
        vecs[6]  = '{"imiss",           0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0, V_IMISS};
        vecs[7]  = '{"loaduse_vs_imiss",0,0,0,0,1, 5'd4, 5'd4, 5'd0, 0,0,0, V_LOADUSE};
        vecs[8]  = '{"redir_vs_imiss",  0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,1,0, V_REDIR};
        vecs[9]  = '{"redir_vs_lu",     1,0,0,0,1, 5'd4, 5'd4, 5'd0, 0,1,0, V_REDIR};
        vecs[10] = '{"halt_vs_redir",   1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,1,1, V_HALT};
        vecs[11] = '{"memwait_ld_halt", 1,0,1,0,1, 5'd4, 5'd4, 5'd0, 0,1,1, V_MEMWAIT};
        vecs[12] = '{"memwait_st",      0,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0,0, V_MEMWAIT};
        vecs[13] = '{"load_dhit",       1,1,1,0,0, 5'd0, 5'd0, 5'd0, 0,0,0, V_NORMAL};
        vecs[14] = '{"no_mem_nodhit",   1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0, V_NORMAL};

        // Reset state while RST is held.
        RST = 1'b1;
        set_idle();
        #1;
        check("reset_outs", {7'd0, outs}, {7'd0, V_RESET});
        check("reset_halted", {15'd0, halted}, 16'd0);
        check("reset_stall", stall_cycles, 16'd0);
        check("reset_flush_ev", flush_events, 16'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Single-cycle decode table, always evaluated from RUN; inputs return
        // to idle before each rising edge so the state stays RUN.
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            ihit = vecs[i].ihit; dhit = vecs[i].dhit;
            dmemREN_MEM = vecs[i].ren; dmemWEN_MEM = vecs[i].wen;
            memtoReg_EX = vecs[i].m2r; Wsel_EX = vecs[i].wsel;
            rs_ID = vecs[i].rs; rt_ID = vecs[i].rt; usesRt_ID = vecs[i].usesrt;
            redirect_MEM = vecs[i].redir; halt_MEM = vecs[i].halt;
            #1;
            check(vecs[i].name, {7'd0, outs}, {7'd0, vecs[i].exp});
            check({vecs[i].name, "_halted"}, {15'd0, halted}, 16'd0);
            set_idle();
        end

        // Memory wait: three frozen cycles, then dhit resolves as RUN.
        do_reset();
        dmemREN_MEM = 1'b1; dhit = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("memwait_c%0d", c), {7'd0, outs}, {7'd0, V_MEMWAIT});
            @(negedge CLK);
        end
        dhit = 1'b1;
        #1;
        check("memwait_release", {7'd0, outs}, {7'd0, V_NORMAL});
`ifdef PIPE_PERF_CNT_EN
        check("memwait_stall_cnt", stall_cycles, 16'd3);
`else
        check("memwait_stall_cnt", stall_cycles, 16'd0);
`endif
        @(negedge CLK);
        set_idle();
        #1;
        check("after_memwait", {7'd0, outs}, {7'd0, V_NORMAL});

        // Halt arriving while memwait holds is deferred until dhit.
        do_reset();
        dmemREN_MEM = 1'b1; halt_MEM = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        #1;
        check("halt_deferred", {7'd0, outs}, {7'd0, V_MEMWAIT});
        dhit = 1'b1;
        #1;
        check("halt_after_dhit", {7'd0, outs}, {7'd0, V_HALT});
        @(negedge CLK);
        set_idle();
        #1;
        check("deferred_drain", {7'd0, outs}, {7'd0, V_DRAIN});

        // Redirect during a fetch miss.
        do_reset();
        redirect_MEM = 1'b1; ihit = 1'b0;
        #1;
        check("redirect_miss", {7'd0, outs}, {7'd0, V_REDIR});
        @(negedge CLK);
        set_idle();
        #1;
`ifdef PIPE_PERF_CNT_EN
        check("flush_events", flush_events, 16'd1);
`else
        check("flush_events", flush_events, 16'd0);
`endif

        // Halt -> DRAIN -> HALTED, sticky under random inputs.
        do_reset();
        halt_MEM = 1'b1;
        #1;
        check("halt_cycle", {7'd0, outs}, {7'd0, V_HALT});
        @(negedge CLK);
        set_idle();
        #1;
        check("drain_outs", {7'd0, outs}, {7'd0, V_DRAIN});
        check("drain_halted", {15'd0, halted}, 16'd0);
        @(negedge CLK);
        #1;
        check("halted_outs", {7'd0, outs}, {7'd0, V_HALTED});
        check("halted_flag", {15'd0, halted}, 16'd1);
        begin
            logic [15:0] frozen_stall;
            frozen_stall = stall_cycles;
            for (int c = 0; c < 20; c++) begin
                @(negedge CLK);
                {ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX,
                 usesRt_ID, redirect_MEM, halt_MEM} = 8'($urandom);
                Wsel_EX = 5'($urandom); rs_ID = 5'($urandom); rt_ID = 5'($urandom);
                #1;
                check($sformatf("halted_rand_%0d", c), {6'd0, halted, outs}, {6'd0, 1'b1, V_HALTED});
            end
            check("halted_stall_frozen", stall_cycles, frozen_stall);
        end

        // Reset asserted mid-wait takes effect without a clock edge.
        do_reset();
        dmemREN_MEM = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        #1;
        check("pre_reset_wait", {7'd0, outs}, {7'd0, V_MEMWAIT});
        #2;
        RST = 1'b1;
        #1;
        check("reset_mid_wait", {7'd0, outs}, {7'd0, V_RESET});
        check("reset_mid_stall", stall_cycles, 16'd0);
        @(negedge CLK);
        RST = 1'b0;
        set_idle();
        #1;
        check("post_reset_run", {7'd0, outs}, {7'd0, V_NORMAL});
        @(negedge CLK);
        #1;
        check("post_reset_run2", {7'd0, outs}, {7'd0, V_NORMAL});

        // Saturation of the stall counter under a long fetch miss.
        do_reset();
        ihit = 1'b0;
`ifdef PIPE_PERF_CNT_EN
        repeat (70000) @(negedge CLK);
        #1;
        check("stall_saturate", stall_cycles, 16'hFFFF);
`else
        repeat (200) @(negedge CLK);
        #1;
        check("stall_tied_zero", stall_cycles, 16'd0);
`endif
        check("imiss_long", {7'd0, outs}, {7'd0, V_IMISS});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports ihit  in  1  (instruction fetch complete this cycle) and dhit  in  1  (data access complete this cycle).
REQ-004 SHALL have ports dmemREN_MEM  in  1 and dmemWEN_MEM  in  1  (MEM-stage load/store pending).
REQ-005 SHALL have ports memtoReg_EX  in  1  (EX instruction is a load) and Wsel_EX  in  5  (its destination register).
REQ-006 SHALL have ports rs_ID  in  5, rt_ID  in  5 and usesRt_ID  in  1  (ID instruction reads rt).
REQ-007 SHALL have ports redirect_MEM  in  1  (taken branch/jump resolved in MEM) and halt_MEM  in  1  (halt instruction in MEM).
REQ-008 SHALL have outputs pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush, each  out  1, driving the four pipeline latches.
REQ-009 SHALL have output halted  out  1  (processor stopped).
REQ-010 SHALL have outputs stall_cycles  out  16 and flush_events  out  16  (performance counters).

Function
REQ-011 SHALL implement FSM states RUN, MEMWAIT, DRAIN and HALTED; outputs are combinational from state and inputs.
REQ-012 SHALL define memwait = (dmemREN_MEM | dmemWEN_MEM) & !dhit.
REQ-013 SHALL define loaduse = memtoReg_EX & Wsel_EX != 0 & (Wsel_EX == rs_ID | (usesRt_ID & Wsel_EX == rt_ID)).
REQ-014 SHALL resolve RUN/MEMWAIT events by priority: memwait > halt_MEM > redirect_MEM > loaduse > !ihit > normal.
REQ-015 SHALL, on normal, assert every en, deassert every flush.
REQ-016 SHALL, on memwait: pc_en/ifid_en/idex_en/exmem_en = 0, memwb_flush = 1; state -> MEMWAIT; MEMWAIT -> RUN in the cycle dhit = 1, with that cycle evaluated as RUN.
REQ-017 SHALL, on halt_MEM: pc_en = 0, ifid_flush/idex_flush/exmem_flush = 1, memwb_en = 1; state -> DRAIN.
REQ-018 SHALL, in DRAIN: all en = 0, memwb_flush = 1; state -> HALTED next cycle.
REQ-019 SHALL, in HALTED: all en = 0, all flushes = 0, halted = 1; remain until RST.
REQ-020 SHALL, on redirect_MEM: pc_en = 1, ifid_flush/idex_flush/exmem_flush = 1, memwb_en = 1, regardless of ihit.
REQ-021 SHALL, on loaduse: pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en/memwb_en = 1 (one bubble per cycle loaduse holds).
REQ-022 SHALL, on !ihit: pc_en = 0, ifid_flush = 1, idex_en/exmem_en/memwb_en = 1.
REQ-023 SHALL treat flush as overriding en on the same latch; en SHALL be driven 0 whenever flush is 1.
REQ-024 SHALL ignore redirect_MEM, halt_MEM and loaduse while memwait holds; they are re-evaluated once dhit arrives.

Reset
REQ-025 SHALL, while RST = 1, force state RUN, all en = 0, all flushes = 1, halted = 0, counters = 0.
REQ-026 SHALL take effect immediately on RST assertion from any state, including MEMWAIT and DRAIN; first active edge after deassertion evaluates RUN.

Configuration
REQ-027 SHALL provide macro PIPE_PERF_CNT_EN.
REQ-028 SHALL, with PIPE_PERF_CNT_EN defined: stall_cycles +1 each cycle pc_en = 0 in RUN or MEMWAIT; flush_events +1 each cycle redirect_MEM takes effect; both saturate at 16'hFFFF; both freeze in DRAIN/HALTED.
REQ-029 SHALL, without PIPE_PERF_CNT_EN: stall_cycles and flush_events tied to 0, no counter registers; all other behaviour identical.

Verification
REQ-030 Load-use: memtoReg_EX = 1, Wsel_EX = 5, rs_ID = 5, ihit = 1 -> pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en = 1 for that cycle; Wsel_EX = 0 instead -> normal.
REQ-031 Memory wait: dmemREN_MEM = 1, dhit = 0 for 3 cycles then 1 -> 3 frozen cycles with memwb_flush = 1, state MEMWAIT, 4th cycle normal; stall_cycles = 3 (macro on).
REQ-032 Redirect vs fetch miss: redirect_MEM = 1, ihit = 0 -> pc_en = 1, ifid/idex/exmem flushes = 1, flush_events +1.
REQ-033 Halt: halt_MEM = 1 -> DRAIN next cycle, halted = 1 two cycles later, stays 1 with random inputs for 20 cycles, all en = 0.
REQ-034 Reset mid-wait: RST asserted during MEMWAIT -> outputs immediately reset values; after release with ihit = 1 -> all en = 1.
REQ-035 Saturation (macro on): hold !ihit for 70000 cycles -> stall_cycles = 16'hFFFF, no wrap; macro off -> 0.
